// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared types and sizing helper for the serializer
package serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } ser_state_t;

  // Counter width for a modulo-n count; a width of zero is never legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_bit_timer.sv
// rtl/serializer_bit_timer.sv - bit period counter with enable/clear and terminal-count tick
module bit_timer
  import serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial transmitter with valid/ready input and abort
// Optional even parity bit when SERIALIZER_PARITY_EN is defined.
module serializer
  import serializer_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter int   LSB_FIRST    = 0,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_en,
  output logic             bit_strobe,
  output logic             done,
  output logic             busy
);

  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WIDTH - 1);

  ser_state_t        state;
  logic [WIDTH-1:0]  shreg;
  logic [BCNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0]  shreg_adv;
  logic              next_bit;
  logic              first_bit;
  logic              accept;
  logic              timer_en;
  logic              tick;
`ifdef SERIALIZER_PARITY_EN
  logic              parity;
`endif

  assign din_ready = (state == S_IDLE) || (state == S_DONE);
  assign accept    = din_valid & din_ready & ~abort;
  assign timer_en  = (state == S_SHIFT) || (state == S_PARITY);

  // next_bit is the bit that lands on ser_out once the register advances.
  assign shreg_adv = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
  assign next_bit  = (LSB_FIRST != 0) ? shreg[1] : shreg[WIDTH-2];
  assign first_bit = (LSB_FIRST != 0) ? din[0] : din[WIDTH-1];

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (timer_en),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_en     <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state      <= S_SHIFT;
            shreg      <= din;
            bit_cnt    <= '0;
            ser_out    <= first_bit;
            ser_en     <= 1'b1;
            busy       <= 1'b1;
            bit_strobe <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity     <= ^din;
`endif
          end else begin
            state   <= S_IDLE;
            ser_out <= IDLE_LEVEL;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            state   <= S_IDLE;
            ser_out <= IDLE_LEVEL;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (tick) begin
            shreg   <= shreg_adv;
            bit_cnt <= bit_cnt + BCNT_W'(1);
            if (bit_cnt == LAST_BIT) begin
`ifdef SERIALIZER_PARITY_EN
              state      <= S_PARITY;
              ser_out    <= parity;
              bit_strobe <= 1'b1;
`else
              state   <= S_DONE;
              done    <= 1'b1;
              ser_out <= IDLE_LEVEL;
              ser_en  <= 1'b0;
              busy    <= 1'b0;
`endif
            end else begin
              ser_out    <= next_bit;
              bit_strobe <= 1'b1;
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        S_PARITY: begin
          if (abort) begin
            state   <= S_IDLE;
            ser_out <= IDLE_LEVEL;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
          end else if (tick) begin
            state   <= S_DONE;
            done    <= 1'b1;
            ser_out <= IDLE_LEVEL;
            ser_en  <= 1'b0;
            busy    <= 1'b0;
          end
        end
`endif
        default: begin
          state   <= S_IDLE;
          ser_out <= IDLE_LEVEL;
          ser_en  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed self-checking bench for serializer (two configurations)
module tb_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int F = 9;
`else
  localparam int F = 8;
`endif

  logic       clk;
  logic       rst_n;

  logic [7:0] a_din;
  logic       a_valid, a_abort;
  logic       a_ready, a_ser, a_en, a_strb, a_done, a_busy;

  logic [7:0] b_din;
  logic       b_valid, b_abort;
  logic       b_ready, b_ser, b_en, b_strb, b_done, b_busy;

  int checks = 0;
  int errors = 0;

  serializer #(
    .WIDTH(8), .CLKS_PER_BIT(1), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
    .abort(a_abort), .ser_out(a_ser), .ser_en(a_en), .bit_strobe(a_strb),
    .done(a_done), .busy(a_busy)
  );

  serializer #(
    .WIDTH(8), .CLKS_PER_BIT(3), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
    .abort(b_abort), .ser_out(b_ser), .ser_en(b_en), .bit_strobe(b_strb),
    .done(b_done), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Full frame on u_a (1 clock per bit, MSB first, idle 0).
  task automatic frame_a(input logic [7:0] d);
    int   strobes;
    logic exp;
    strobes = 0;
    a_din   = d;
    a_valid = 1'b1;
    check("a_ready_pre", a_ready, 1);
    step;
    a_valid = 1'b0;
    for (int n = 0; n < F; n++) begin
      exp = (n < 8) ? d[7-n] : ^d;
      check("a_bit", a_ser, exp);
      check("a_en", a_en, 1);
      check("a_busy", a_busy, 1);
      check("a_done_mid", a_done, 0);
      check("a_ready_mid", a_ready, 0);
      strobes += a_strb;
      step;
    end
    check("a_strobes", strobes, F);
    check("a_done", a_done, 1);
    check("a_en_done", a_en, 0);
    check("a_busy_done", a_busy, 0);
    check("a_ser_done", a_ser, 0);
    check("a_ready_done", a_ready, 1);
    step;
    check("a_done_once", a_done, 0);
  endtask

  // Full frame on u_b (3 clocks per bit, LSB first, idle 1).
  task automatic frame_b(input logic [7:0] d);
    int   strobes;
    logic exp;
    strobes = 0;
    b_din   = d;
    b_valid = 1'b1;
    check("b_ready_pre", b_ready, 1);
    step;
    b_valid = 1'b0;
    for (int n = 0; n < F; n++) begin
      exp = (n < 8) ? d[n] : ^d;
      for (int c = 0; c < 3; c++) begin
        check("b_bit", b_ser, exp);
        check("b_en", b_en, 1);
        check("b_strobe", b_strb, (c == 0) ? 1 : 0);
        check("b_done_mid", b_done, 0);
        strobes += b_strb;
        step;
      end
    end
    check("b_strobes", strobes, F);
    check("b_done", b_done, 1);
    check("b_en_done", b_en, 0);
    check("b_ser_done", b_ser, 1);
    step;
    check("b_done_once", b_done, 0);
  endtask

  initial begin
    int ndone;
    clk = 0; rst_n = 0;
    a_din = 0; a_valid = 0; a_abort = 0;
    b_din = 0; b_valid = 0; b_abort = 0;

    #12;
    check("rst_a_ser", a_ser, 0);
    check("rst_a_en", a_en, 0);
    check("rst_a_strb", a_strb, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ser", b_ser, 1);
    @(negedge clk);
    rst_n = 1;
    step;

    frame_a(8'hA5);
    frame_b(8'h1E);

    // Back-to-back FF then 00 with din_valid held.
    a_din = 8'hFF; a_valid = 1'b1;
    step;
    a_din = 8'h00;
    for (int n = 0; n < F; n++) begin
      check("b2b_ready_low", a_ready, 0);
      check("b2b_bit1", a_ser, (n < 8) ? 1 : 0);
      step;
    end
    check("b2b_done1", a_done, 1);
    check("b2b_ready_hi", a_ready, 1);
    step;
    a_valid = 1'b0;
    for (int n = 0; n < F; n++) begin
      check("b2b_bit2", a_ser, 0);
      check("b2b_strb2", a_strb, 1);
      check("b2b_en2", a_en, 1);
      step;
    end
    check("b2b_done2", a_done, 1);
    step;

    // Abort during bit 4 of A5.
    a_din = 8'hA5; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    repeat (4) step;
    check("abort_at_bit4_strb", a_strb, 1);
    check("abort_at_bit4_en", a_en, 1);
    a_abort = 1'b1;
    step;
    a_abort = 1'b0;
    check("abort_en", a_en, 0);
    check("abort_busy", a_busy, 0);
    check("abort_ser", a_ser, 0);
    check("abort_ready", a_ready, 1);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      ndone += a_done;
      step;
    end
    check("abort_no_done", ndone, 0);

    // Abort while idle blocks acceptance.
    a_din = 8'h5A; a_valid = 1'b1; a_abort = 1'b1;
    step;
    check("idle_abort_busy", a_busy, 0);
    check("idle_abort_en", a_en, 0);
    a_valid = 1'b0; a_abort = 1'b0;
    step;

    // Abort in the done cycle: done still pulses, no accept.
    a_din = 8'h3C; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    repeat (F) step;
    check("done_abort_done", a_done, 1);
    a_valid = 1'b1; a_abort = 1'b1;
    step;
    a_valid = 1'b0; a_abort = 1'b0;
    check("done_abort_busy", a_busy, 0);
    check("done_abort_en", a_en, 0);
    check("done_abort_done_clr", a_done, 0);
    step;

    // Reset pulsed during bit 2 of a u_b frame.
    b_din = 8'h00; b_valid = 1'b1;
    step;
    b_valid = 1'b0;
    repeat (6) step;
    check("pre_rst_strb", b_strb, 1);
    check("pre_rst_ser", b_ser, 0);
    rst_n = 0;
    #1;
    check("mid_rst_ser", b_ser, 1);
    check("mid_rst_en", b_en, 0);
    check("mid_rst_strb", b_strb, 0);
    check("mid_rst_busy", b_busy, 0);
    check("mid_rst_done", b_done, 0);
    check("mid_rst_ready", b_ready, 1);
    @(negedge clk);
    rst_n = 1;
    step;
    frame_b(8'hC3);

`ifdef SERIALIZER_PARITY_EN
    frame_a(8'h07);
    frame_a(8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
